// File: rtl/piso_pkg.sv
// Shared definitions for the PISO serializer controller: FSM state encoding
// and width helpers used to size the controller's counters.
package piso_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_SHIFT = 2'd1;
    localparam state_t ST_GAP   = 2'd2;

    // A zero-length gap still needs a 1-bit counter so the port/flop stays legal.
    function automatic int gap_cnt_width(input int gap);
        int w;
        w = $clog2(gap + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/piso_tx_ctrl_shreg_core.sv
// WIDTH-bit shift register with sync clear, parallel load and MSB-first
// left shift (zero fill); clear beats load, load beats shift.
module shreg_core #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             ld,
    input  logic             shift,
    input  logic [WIDTH-1:0] d,
    output logic             msb
);

    logic [WIDTH-1:0] sr_q;
    logic [WIDTH-1:0] sr_d;

    always_comb begin
        sr_d = sr_q;
        if (clr) begin
            sr_d = '0;
        end else if (ld) begin
            sr_d = d;
        end else if (shift) begin
            sr_d = {sr_q[WIDTH-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk) begin
        sr_q <= sr_d;
    end

    assign msb = sr_q[WIDTH-1];

endmodule

// File: rtl/piso_tx_ctrl.sv
// Serializer controller: accepts words on valid/ready, shifts them out
// MSB-first with frame markers, and inserts a programmable idle gap.
module piso_tx_ctrl
    import piso_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int GAP   = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     abort,
    output logic                     sdo,
    output logic                     sdo_valid,
    output logic                     frame_start,
    output logic                     frame_end,
    output logic                     busy,
    output logic [$clog2(WIDTH)-1:0] bit_cnt
);

    localparam int CNT_W  = $clog2(WIDTH);
    localparam int GAP_CW = gap_cnt_width(GAP);
    localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(WIDTH - 1);
    localparam logic [GAP_CW-1:0] GAP_LAST = GAP_CW'((GAP > 0) ? GAP - 1 : 0);

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [GAP_CW-1:0]   gap_cnt_q, gap_cnt_d;
    logic                sr_clr, sr_ld, sr_shift;
    logic                sr_msb;
    logic                last_bit;
    logic                accept;

    assign last_bit = (bit_cnt_q == LAST_BIT);

    // With no gap the last bit cycle doubles as an accept slot, giving
    // seamless back-to-back frames.
    assign in_ready = !rst && !abort &&
                      ((state_q == ST_IDLE) ||
                       ((GAP == 0) && (state_q == ST_SHIFT) && last_bit));
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        gap_cnt_d = gap_cnt_q;
        sr_clr    = 1'b0;
        sr_ld     = 1'b0;
        sr_shift  = 1'b0;
        if (rst || (abort && (state_q != ST_IDLE))) begin
            state_d   = ST_IDLE;
            bit_cnt_d = '0;
            gap_cnt_d = '0;
            sr_clr    = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        state_d   = ST_SHIFT;
                        bit_cnt_d = '0;
                        sr_ld     = 1'b1;
                    end
                end
                ST_SHIFT: begin
                    if (!last_bit) begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        sr_shift  = 1'b1;
                    end else if (accept) begin
                        bit_cnt_d = '0;
                        sr_ld     = 1'b1;
                    end else begin
                        state_d   = (GAP > 0) ? ST_GAP : ST_IDLE;
                        bit_cnt_d = '0;
                        gap_cnt_d = '0;
                        sr_clr    = 1'b1;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt_q == GAP_LAST) begin
                        state_d   = ST_IDLE;
                        gap_cnt_d = '0;
                    end else begin
                        gap_cnt_d = gap_cnt_q + GAP_CW'(1);
                    end
                end
                default: begin
                    state_d   = ST_IDLE;
                    bit_cnt_d = '0;
                    gap_cnt_d = '0;
                    sr_clr    = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            gap_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            gap_cnt_q <= gap_cnt_d;
        end
    end

    shreg_core #(
        .WIDTH (WIDTH)
    ) u_shreg (
        .clk   (clk),
        .clr   (sr_clr),
        .ld    (sr_ld),
        .shift (sr_shift),
        .d     (in_data),
        .msb   (sr_msb)
    );

    // An aborted frame must never signal its end, even on its last bit.
    assign sdo_valid   = !rst && (state_q == ST_SHIFT);
    assign sdo         = sdo_valid && sr_msb;
    assign frame_start = sdo_valid && (bit_cnt_q == '0);
    assign frame_end   = sdo_valid && last_bit && !abort;
    assign busy        = !rst && (state_q != ST_IDLE);
    assign bit_cnt     = rst ? '0 : bit_cnt_q;

endmodule

// File: tb/tb_piso_tx_ctrl.sv
// Directed bench for piso_tx_ctrl: one instance with GAP=1 and one with GAP=0.
module tb_piso_tx_ctrl;

    logic       clk = 1'b0;
    int         checks = 0;
    int         errors = 0;

    logic       rst_a, in_valid_a, abort_a, in_ready_a, sdo_a, sdo_valid_a;
    logic       frame_start_a, frame_end_a, busy_a;
    logic [3:0] in_data_a;
    logic [1:0] bit_cnt_a;

    logic       rst_b, in_valid_b, abort_b, in_ready_b, sdo_b, sdo_valid_b;
    logic       frame_start_b, frame_end_b, busy_b;
    logic [3:0] in_data_b;
    logic [1:0] bit_cnt_b;

    always #5 clk = ~clk;

    piso_tx_ctrl #(.WIDTH(4), .GAP(1)) dut_a (
        .clk(clk), .rst(rst_a), .in_data(in_data_a), .in_valid(in_valid_a),
        .in_ready(in_ready_a), .abort(abort_a), .sdo(sdo_a), .sdo_valid(sdo_valid_a),
        .frame_start(frame_start_a), .frame_end(frame_end_a), .busy(busy_a),
        .bit_cnt(bit_cnt_a)
    );

    piso_tx_ctrl #(.WIDTH(4), .GAP(0)) dut_b (
        .clk(clk), .rst(rst_b), .in_data(in_data_b), .in_valid(in_valid_b),
        .in_ready(in_ready_b), .abort(abort_b), .sdo(sdo_b), .sdo_valid(sdo_valid_b),
        .frame_start(frame_start_b), .frame_end(frame_end_b), .busy(busy_b),
        .bit_cnt(bit_cnt_b)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected vector order: {in_ready, sdo_valid, sdo, frame_start, frame_end, busy}
    task automatic cyc_a(input string tag, input logic r, input logic ab, input logic v,
                         input logic [3:0] d, input logic [5:0] exp);
        @(posedge clk);
        #1;
        rst_a = r; abort_a = ab; in_valid_a = v; in_data_a = d;
        #1;
        chk(tag, {2'b00, in_ready_a, sdo_valid_a, sdo_a, frame_start_a, frame_end_a, busy_a},
            {2'b00, exp});
    endtask

    task automatic cyc_b(input string tag, input logic r, input logic ab, input logic v,
                         input logic [3:0] d, input logic [5:0] exp);
        @(posedge clk);
        #1;
        rst_b = r; abort_b = ab; in_valid_b = v; in_data_b = d;
        #1;
        chk(tag, {2'b00, in_ready_b, sdo_valid_b, sdo_b, frame_start_b, frame_end_b, busy_b},
            {2'b00, exp});
    endtask

    initial begin
        rst_a = 1'b1; abort_a = 1'b0; in_valid_a = 1'b0; in_data_a = 4'h0;
        rst_b = 1'b1; abort_b = 1'b0; in_valid_b = 1'b0; in_data_b = 4'h0;

        // Reset: everything low, including in_ready
        cyc_a("rst_a0", 1, 0, 0, 4'h0, 6'b000000);
        cyc_b("rst_b0", 1, 0, 0, 4'h0, 6'b000000);
        cyc_a("rst_a1", 1, 0, 0, 4'h0, 6'b000000);
        chk("rst_bitcnt_a", {6'b0, bit_cnt_a}, 8'd0);
        cyc_b("rst_b1", 0, 0, 0, 4'h0, 6'b100000);
        cyc_a("rel_a", 0, 0, 0, 4'h0, 6'b100000);

        // Basic frame 1011 with GAP=1
        cyc_a("t1_c0", 0, 0, 1, 4'b1011, 6'b100000);
        cyc_a("t1_c1", 0, 0, 0, 4'h0, 6'b011101);
        chk("t1_bitcnt1", {6'b0, bit_cnt_a}, 8'd0);
        cyc_a("t1_c2", 0, 0, 0, 4'h0, 6'b010001);
        cyc_a("t1_c3", 0, 0, 0, 4'h0, 6'b011001);
        cyc_a("t1_c4", 0, 0, 0, 4'h0, 6'b011011);
        chk("t1_bitcnt4", {6'b0, bit_cnt_a}, 8'd3);
        cyc_a("t1_c5", 0, 0, 0, 4'h0, 6'b000001);
        cyc_a("t1_c6", 0, 0, 0, 4'h0, 6'b100000);

        // GAP=0 back-to-back: 1100 then 0011 with in_valid held
        cyc_b("t2_c0", 0, 0, 1, 4'b1100, 6'b100000);
        cyc_b("t2_c1", 0, 0, 1, 4'b0011, 6'b011101);
        cyc_b("t2_c2", 0, 0, 1, 4'b0011, 6'b011001);
        cyc_b("t2_c3", 0, 0, 1, 4'b0011, 6'b010001);
        cyc_b("t2_c4", 0, 0, 1, 4'b0011, 6'b110011);
        cyc_b("t2_c5", 0, 0, 0, 4'h0, 6'b010101);
        chk("t2_bitcnt5", {6'b0, bit_cnt_b}, 8'd0);
        cyc_b("t2_c6", 0, 0, 0, 4'h0, 6'b010001);
        cyc_b("t2_c7", 0, 0, 0, 4'h0, 6'b011001);
        cyc_b("t2_c8", 0, 0, 0, 4'h0, 6'b111011);
        cyc_b("t2_c9", 0, 0, 0, 4'h0, 6'b100000);

        // Abort in cycle 2 of 1111, then a full 1011 frame
        cyc_a("t3_c0", 0, 0, 1, 4'b1111, 6'b100000);
        cyc_a("t3_c1", 0, 0, 0, 4'h0, 6'b011101);
        cyc_a("t3_c2", 0, 1, 0, 4'h0, 6'b011001);
        cyc_a("t3_c3", 0, 0, 1, 4'b1011, 6'b100000);
        chk("t3_bitcnt3", {6'b0, bit_cnt_a}, 8'd0);
        cyc_a("t3_c4", 0, 0, 0, 4'h0, 6'b011101);
        cyc_a("t3_c5", 0, 0, 0, 4'h0, 6'b010001);
        cyc_a("t3_c6", 0, 0, 0, 4'h0, 6'b011001);
        cyc_a("t3_c7", 0, 0, 0, 4'h0, 6'b011011);
        cyc_a("t3_c8", 0, 0, 0, 4'h0, 6'b000001);
        cyc_a("t3_c9", 0, 0, 0, 4'h0, 6'b100000);

        // Reset in cycle 3 mid-frame
        cyc_a("t4_c0", 0, 0, 1, 4'b1011, 6'b100000);
        cyc_a("t4_c1", 0, 0, 0, 4'h0, 6'b011101);
        cyc_a("t4_c2", 0, 0, 0, 4'h0, 6'b010001);
        cyc_a("t4_c3", 1, 0, 0, 4'h0, 6'b000000);
        chk("t4_bitcnt3", {6'b0, bit_cnt_a}, 8'd0);
        cyc_a("t4_c4", 1, 0, 0, 4'h0, 6'b000000);
        cyc_a("t4_c5", 0, 0, 0, 4'h0, 6'b100000);
        chk("t4_bitcnt5", {6'b0, bit_cnt_a}, 8'd0);
        cyc_a("t4_c6", 0, 0, 0, 4'h0, 6'b100000);

        // in_valid pulsed with 0110 while busy must be ignored
        cyc_a("t5_c0", 0, 0, 1, 4'b1011, 6'b100000);
        cyc_a("t5_c1", 0, 0, 0, 4'h0, 6'b011101);
        cyc_a("t5_c2", 0, 0, 1, 4'b0110, 6'b010001);
        cyc_a("t5_c3", 0, 0, 0, 4'h0, 6'b011001);
        cyc_a("t5_c4", 0, 0, 0, 4'h0, 6'b011011);
        cyc_a("t5_c5", 0, 0, 0, 4'h0, 6'b000001);
        cyc_a("t5_c6", 0, 0, 0, 4'h0, 6'b100000);
        cyc_a("t5_c7", 0, 0, 0, 4'h0, 6'b100000);

        // Abort with in_valid in IDLE blocks accept for that cycle only
        cyc_a("t6_c0", 0, 1, 1, 4'b0110, 6'b000000);
        cyc_a("t6_c1", 0, 0, 1, 4'b0110, 6'b100000);
        cyc_a("t6_c2", 0, 0, 0, 4'h0, 6'b010101);
        cyc_a("t6_c3", 0, 0, 0, 4'h0, 6'b011001);
        cyc_a("t6_c4", 0, 0, 0, 4'h0, 6'b011001);
        cyc_a("t6_c5", 0, 0, 0, 4'h0, 6'b010011);
        cyc_a("t6_c6", 0, 0, 0, 4'h0, 6'b000001);
        cyc_a("t6_c7", 0, 0, 0, 4'h0, 6'b100000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/piso_tx_ctrl.md
Name: piso_tx_ctrl

Overview:
Serializer controller that sequences a WIDTH-bit shift register through load and shift phases.
- Accepts parallel words on a valid/ready handshake.
- Shifts each word out MSB-first, one bit per clock, with frame markers.
- Inserts a programmable idle gap between frames.
- Sits between a word-producing upstream stage and a serial sink.

Parameters:
- WIDTH, 4, word length in bits; legal range >= 2.
- GAP, 1, idle cycles between the last bit of one frame and the next accept; legal range >= 0.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  reset: synchronous, active-high.
- in_data  input  WIDTH  parallel word to transmit.
- in_valid  input  1  upstream holds in_data valid.
- in_ready  output  1  controller can accept a word this cycle.
- abort  input  1  synchronous frame abort.
- sdo  output  1  serial data bit (MSB-first).
- sdo_valid  output  1  sdo carries a frame bit this cycle.
- frame_start  output  1  high on the first bit of a frame.
- frame_end  output  1  high on the last bit of a frame.
- busy  output  1  high in SHIFT or GAP.
- bit_cnt  output  $clog2(WIDTH)  index of the current bit within the frame (0 = MSB).

Behaviour:
- Reset (rst=1 at posedge):
  - State goes to IDLE; shift register, bit_cnt and gap counter clear to 0.
  - While rst is high, all outputs are forced to 0, including in_ready.
- States: IDLE, SHIFT, GAP.
- IDLE:
  - in_ready=1.
  - Accept occurs when in_valid && in_ready at posedge. The register then loads in_data, state goes to SHIFT and bit_cnt=0.
- SHIFT:
  - sdo = reg[WIDTH-1]; sdo_valid=1.
  - frame_start = (bit_cnt==0); frame_end = (bit_cnt==WIDTH-1).
  - Each posedge: reg shifts left with 0 into the LSB, and bit_cnt increments.
  - On the frame_end cycle: next state is GAP if GAP>0, else IDLE-equivalent.
- GAP==0 back-to-back case:
  - in_ready is also 1 during the frame_end cycle.
  - An accept in that cycle loads the new word directly and stays in SHIFT with bit_cnt=0.
  - There is no bubble; sdo_valid stays continuously high.
- GAP:
  - sdo_valid=0, sdo=0, in_ready=0.
  - Counter runs from 0 to GAP-1, then the state goes to IDLE.
- Latency: accept at posedge k gives the first bit visible in cycle k+1 and the last bit in cycle k+WIDTH. With GAP>0, in_ready reasserts in cycle k+WIDTH+GAP+1.
- sdo_valid=0 implies sdo=0, frame_start=0, frame_end=0.
- in_valid while not ready: ignored; the word is not consumed. The upstream holds the word per handshake rules.
- abort:
  - In SHIFT or GAP: next state IDLE; reg, bit_cnt and gap counter cleared.
  - frame_end is not produced for an aborted frame.
  - abort has priority over a coincident accept; during the abort cycle, in_ready=0.
  - In IDLE: no effect, except that in_ready=0 for that cycle.
- Priority: rst > abort > accept > shift.
- Reset mid-frame: immediate return to IDLE on the next posedge; no partial frame resumes.
- bit_cnt wraps only via reload or return to IDLE; it never exceeds WIDTH-1.

Decomposition:
- Shared package piso_pkg:
  - state enum (IDLE, SHIFT, GAP);
  - localparam CNT_W = $clog2(WIDTH);
  - gap counter width = $clog2(GAP+1), with a minimum of 1.
- One natural sub-module, shreg_core: the WIDTH-bit register with sync clear, ld and left-shift-with-zero-fill, where ld has priority over shift. piso_tx_ctrl instantiates it and drives clr/ld/shift from the FSM.

Test Plan:
- WIDTH=4, GAP=1, in_data=4'b1011 accepted at cycle 0:
  - sdo = 1,0,1,1 in cycles 1-4;
  - frame_start in cycle 1 only, frame_end in cycle 4 only;
  - cycle 5 idle with in_ready=0; in_ready=1 from cycle 6.
- GAP=0, two words 4'b1100 then 4'b0011 with in_valid held high:
  - sdo = 1,1,0,0,0,0,1,1 in cycles 1-8;
  - sdo_valid continuously 1;
  - frame_end in cycles 4 and 8.
- abort in cycle 2 of 4'b1111:
  - sdo_valid=0 from cycle 3;
  - no frame_end;
  - in_ready=1 in cycle 3; the next word transmits fully.
- rst asserted in cycle 3 mid-frame:
  - all outputs 0 while rst is high;
  - after release, state is IDLE, in_ready=1, bit_cnt=0.
- in_valid pulsed with 4'b0110 while busy (cycle 2 of a frame):
  - word is not consumed;
  - current frame bits are unchanged.
- Simultaneous abort and in_valid in IDLE: no accept that cycle; accept occurs in the next cycle if in_valid is still high.
